// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: signal bundle between the multicycle controller and the datapath/memory
interface mc_ctrl_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_retired;
  logic [3:0]       state_dbg;
  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, instr_retired, state_dbg
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, instr_retired, state_dbg
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main controller sequencing fetch/decode/execute/mem/writeback
module mc_ctrl_fsm #(parameter int CNT_W = 32) (
  input logic             clk,
  input logic             rst,
  mc_ctrl_fsm_if.master   bus_io
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
    R_WB, BRANCH, JUMP, JAL, JR, ADDI_EX, ADDI_WB
  } state_t;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctl_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, FN_JR = 6'b001000;
  state_t           state_q, state_d;
  ctl_t             ctl_q;
  logic             bne_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal;
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:            begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
      DECODE:           c.alu_src_b = 2'd3;
      MEM_ADDR, ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      MEM_RD:           begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEM_WR:           begin c.mem_write = 1'b1; c.iord = 1'b1; end
      MEM_WB:           begin c.reg_write = 1'b1; c.mem_to_reg = 2'd1; end
      EXEC_R:           begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      R_WB:             begin c.reg_write = 1'b1; c.reg_dst = 2'd1; end
      BRANCH:           begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'd1; end
      JUMP:             begin c.pc_src = 2'd2; c.pc_write = 1'b1; end
      JAL:              begin c.pc_src = 2'd2; c.pc_write = 1'b1; c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
      JR:               begin c.pc_src = 2'd3; c.pc_write = 1'b1; end
      ADDI_WB:          c.reg_write = 1'b1;
      default:          c = '0;
    endcase
    return c;
  endfunction
  // next-state selection; an undecodable opcode in DECODE falls straight back to FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = bus_io.mem_ready ? DECODE : FETCH;
      DECODE:   state_d = bus_io.opcode == OP_R ? (bus_io.funct == FN_JR ? JR : EXEC_R)
                        : (bus_io.opcode == OP_LW || bus_io.opcode == OP_SW) ? MEM_ADDR
                        : (bus_io.opcode == OP_BEQ || bus_io.opcode == OP_BNE) ? BRANCH
                        : bus_io.opcode == OP_ADDI ? ADDI_EX
                        : bus_io.opcode == OP_J ? JUMP
                        : bus_io.opcode == OP_JAL ? JAL
                        : FETCH;
      MEM_ADDR: state_d = bus_io.opcode == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:   state_d = bus_io.mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   state_d = bus_io.mem_ready ? FETCH : MEM_WR;
      EXEC_R:   state_d = R_WB;
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
    illegal = (state_q == DECODE) && (state_d == FETCH);
  end
  // state register, Moore outputs registered from the next state, branch sense and retire count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ctl_q     <= decode(FETCH);
      bne_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d);
      if (state_q == DECODE) bne_q <= bus_io.opcode == OP_BNE;
      if (state_d == FETCH && state_q != FETCH && state_q != DECODE) retired_q <= retired_q + CNT_W'(1);
    end
  end
  assign bus_io.mem_read      = ~rst & ctl_q.mem_read;
  assign bus_io.mem_write     = ~rst & ctl_q.mem_write;
  assign bus_io.iord          = ctl_q.iord;
  assign bus_io.ir_write      = ~rst & (state_q == FETCH) & bus_io.mem_ready;
  assign bus_io.pc_write      = ~rst & (ctl_q.pc_write | ((state_q == FETCH) & bus_io.mem_ready)
                                       | ((state_q == BRANCH) & (bus_io.zero ^ bne_q)));
  assign bus_io.pc_src        = ctl_q.pc_src;
  assign bus_io.alu_src_a     = ctl_q.alu_src_a;
  assign bus_io.alu_src_b     = ctl_q.alu_src_b;
  assign bus_io.alu_op        = ctl_q.alu_op;
  assign bus_io.reg_write     = ~rst & ctl_q.reg_write;
  assign bus_io.reg_dst       = ctl_q.reg_dst;
  assign bus_io.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus_io.illegal_op    = ~rst & illegal;
  assign bus_io.instr_retired = retired_q;
  assign bus_io.state_dbg     = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed instruction stream checked cycle by cycle against a phase-sequence model
module tb_mc_ctrl_fsm;
  localparam int CW = 4;
  localparam logic [3:0] S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5, S_EX = 6;
  localparam logic [3:0] S_RWB = 7, S_BR = 8, S_J = 9, S_JAL = 10, S_JR = 11, S_AE = 12, S_AWB = 13;
  typedef struct packed {
    logic [3:0]    st;
    logic          mrd, mwr, iord, irw, pcw;
    logic [1:0]    pcs;
    logic          asa;
    logic [1:0]    asb, aop;
    logic          rw;
    logic [1:0]    rd, m2r;
    logic          ill;
    logic [CW-1:0] ret;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mc_ctrl_fsm_if #(.CNT_W(CW)) bus();
  mc_ctrl_fsm #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  rec_t q[$];
  int checks = 0, failures = 0, ncyc = 0;
  logic [CW-1:0] ret_m = '0;
  function automatic logic legal(logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03};
  endfunction
  function automatic rec_t exp_of(logic [3:0] ph, logic mr, logic z, logic r, logic [5:0] op);
    rec_t e;
    e = '0;
    e.st = ph;
    e.ret = ret_m;
    case (ph)
      S_F:        begin e.mrd = 1; e.asb = 1; e.irw = mr; e.pcw = mr; end
      S_D:        begin e.asb = 3; e.ill = !legal(op); end
      S_MA, S_AE: begin e.asa = 1; e.asb = 2; end
      S_MR:       begin e.mrd = 1; e.iord = 1; end
      S_MWB:      begin e.rw = 1; e.m2r = 1; end
      S_MW:       begin e.mwr = 1; e.iord = 1; end
      S_EX:       begin e.asa = 1; e.aop = 2; end
      S_RWB:      begin e.rw = 1; e.rd = 1; end
      S_BR:       begin e.asa = 1; e.aop = 1; e.pcs = 1; e.pcw = (op == 6'h04) ? z : !z; end
      S_J:        begin e.pcs = 2; e.pcw = 1; end
      S_JR:       begin e.pcs = 3; e.pcw = 1; end
      S_JAL:      begin e.pcs = 2; e.pcw = 1; e.rw = 1; e.rd = 2; e.m2r = 2; end
      S_AWB:      e.rw = 1;
      default:    e = e;
    endcase
    if (r) begin e.mrd = 0; e.mwr = 0; e.irw = 0; e.pcw = 0; e.rw = 0; e.ill = 0; end
    return e;
  endfunction
  task automatic cyc(logic [3:0] ph, logic mr, logic z, logic r);
    @(posedge clk); #1;
    bus.mem_ready = mr;
    bus.zero = z;
    rst = r;
    q.push_back(exp_of(ph, mr, z, r, bus.opcode));
    ncyc++;
  endtask
  task automatic lit(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic exec(logic [5:0] op, logic [5:0] fn, int fw, int mw, logic z, output int n);
    int s;
    logic [3:0] mp;
    s = ncyc;
    mp = (op == 6'h23) ? S_MR : S_MW;
    for (int i = 0; i < fw; i++) begin cyc(S_F, 0, z, 0); bus.opcode = op; bus.funct = fn; end
    cyc(S_F, 1, z, 0);
    bus.opcode = op;
    bus.funct = fn;
    cyc(S_D, 1, z, 0);
    case (op)
      6'h00: begin
        cyc(fn == 6'h08 ? S_JR : S_EX, 1, z, 0);
        if (fn != 6'h08) cyc(S_RWB, 1, z, 0);
      end
      6'h23, 6'h2b: begin
        cyc(S_MA, 1, z, 0);
        for (int i = 0; i < mw; i++) cyc(mp, 0, z, 0);
        cyc(mp, 1, z, 0);
        if (op == 6'h23) cyc(S_MWB, 1, z, 0);
      end
      6'h04, 6'h05: cyc(S_BR, 1, z, 0);
      6'h08: begin cyc(S_AE, 1, z, 0); cyc(S_AWB, 1, z, 0); end
      6'h02: cyc(S_J, 1, z, 0);
      6'h03: cyc(S_JAL, 1, z, 0);
      default: s = s;
    endcase
    if (legal(op)) ret_m = ret_m + 1'b1;
    n = ncyc - s;
  endtask
  always @(negedge clk) begin : cmp
    rec_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.state_dbg, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
           bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.reg_dst,
           bus.mem_to_reg, bus.illegal_op, bus.instr_retired};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle state=%0d got=%h exp=%h", e.st, a, e);
      end
    end
  end
  initial begin
    int n;
    bus.opcode = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) cyc(S_F, 0, 0, 1);
    repeat (2) cyc(S_F, 0, 0, 0);
    @(negedge clk);
    lit("rst_state", bus.state_dbg, 0);
    lit("rst_mem_read", bus.mem_read, 1);
    lit("rst_ir_write", bus.ir_write, 0);
    lit("rst_pc_write", bus.pc_write, 0);
    lit("rst_retired", bus.instr_retired, 0);
    exec(6'h00, 6'h20, 0, 0, 0, n);
    lit("r_cycles", n, 4);
    @(negedge clk);
    lit("r_wb_reg_dst", bus.reg_dst, 1);
    exec(6'h23, 6'h00, 0, 2, 0, n);
    lit("lw_cycles", n, 7);
    @(negedge clk);
    lit("lw_wb_mem_to_reg", bus.mem_to_reg, 1);
    exec(6'h2b, 6'h00, 1, 1, 0, n);
    lit("sw_cycles", n, 6);
    exec(6'h04, 6'h00, 0, 0, 1, n);
    lit("beq_cycles", n, 3);
    @(negedge clk);
    lit("beq_taken_pc_write", bus.pc_write, 1);
    exec(6'h04, 6'h00, 0, 0, 0, n);
    @(negedge clk);
    lit("beq_not_taken_pc_write", bus.pc_write, 0);
    exec(6'h05, 6'h00, 0, 0, 1, n);
    exec(6'h05, 6'h00, 0, 0, 0, n);
    @(negedge clk);
    lit("bne_taken_pc_write", bus.pc_write, 1);
    exec(6'h02, 6'h00, 0, 0, 0, n);
    exec(6'h03, 6'h00, 0, 0, 0, n);
    @(negedge clk);
    lit("jal_reg_dst", bus.reg_dst, 2);
    exec(6'h00, 6'h08, 0, 0, 0, n);
    lit("jr_cycles", n, 3);
    @(negedge clk);
    lit("jr_pc_src", bus.pc_src, 3);
    exec(6'h08, 6'h00, 0, 0, 0, n);
    lit("addi_cycles", n, 4);
    cyc(S_F, 0, 0, 0);
    @(negedge clk);
    lit("retired_11", bus.instr_retired, 11);
    exec(6'h3f, 6'h00, 0, 0, 0, n);
    lit("illegal_cycles", n, 2);
    @(negedge clk);
    lit("illegal_pulse", bus.illegal_op, 1);
    cyc(S_F, 0, 0, 0);
    @(negedge clk);
    lit("illegal_pulse_end", bus.illegal_op, 0);
    lit("illegal_not_retired", bus.instr_retired, 11);
    cyc(S_F, 1, 0, 0);
    bus.opcode = 6'h2b;
    cyc(S_D, 1, 0, 0);
    cyc(S_MA, 1, 0, 0);
    cyc(S_MW, 0, 0, 0);
    cyc(S_MW, 0, 0, 1);
    @(negedge clk);
    lit("rst_mid_mem_write", bus.mem_write, 0);
    ret_m = '0;
    cyc(S_F, 0, 0, 0);
    @(negedge clk);
    lit("rst_mid_state", bus.state_dbg, 0);
    lit("rst_mid_retired", bus.instr_retired, 0);
    repeat (15) exec(6'h02, 6'h00, 0, 0, 0, n);
    cyc(S_F, 0, 0, 0);
    @(negedge clk);
    lit("retired_max", bus.instr_retired, 15);
    exec(6'h02, 6'h00, 0, 0, 0, n);
    cyc(S_F, 0, 0, 0);
    @(negedge clk);
    lit("retired_wrap", bus.instr_retired, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
